// File: rtl/eq_compute_unit.sv
// eq_compute_unit: flight-equation datapath for the BIST checker.
// Computes either result_a = x1*x1 + x2*v (altitude, sel_eq=0) or
// result_b = t*v + c (battery, sel_eq=1) with a single shared signed
// DWxDW multiplier, sequenced IDLE -> MUL1 -> MUL2 -> ADD -> IDLE.
// Results are saturated to RW bits and held until the next write.

// Shared signed multiplier, purely combinational. Operands are sign-extended
// to the product width so the truncated product is the exact signed result.
module eq_mul #(
   parameter int DW = 8
) (
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [2*DW-1:0] p
);
   logic [2*DW-1:0] a_ext;
   logic [2*DW-1:0] b_ext;

   assign a_ext = {{DW{a[DW-1]}}, a};
   assign b_ext = {{DW{b[DW-1]}}, b};
   assign p     = a_ext * b_ext;
endmodule

module eq_compute_unit #(
   parameter int DW = 8,
   parameter int RW = 16   // must equal 2*DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          sel_eq,
   input  logic [DW-1:0] x1,
   input  logic [DW-1:0] x2,
   input  logic [DW-1:0] v,
   input  logic [DW-1:0] t,
   input  logic [DW-1:0] c,
   output logic [RW-1:0] result_a,
   output logic [RW-1:0] result_b,
   output logic          out_valid,
   output logic          out_sel,
   output logic          sat
);

   typedef enum logic [1:0] {IDLE, MUL1, MUL2, ADD} state_t;

   // Operand set captured at the accept edge; inputs are ignored afterwards.
   typedef struct packed {
      logic          sel;
      logic [DW-1:0] x1;
      logic [DW-1:0] x2;
      logic [DW-1:0] v;
      logic [DW-1:0] t;
      logic [DW-1:0] c;
   } ops_t;

   localparam logic [RW-1:0] SAT_MAX = {1'b0, {(RW-1){1'b1}}};
   localparam logic [RW-1:0] SAT_MIN = {1'b1, {(RW-1){1'b0}}};

   state_t          state;
   ops_t            ops;
   logic [RW-1:0]   p0;
   logic [RW-1:0]   p1;

   logic [DW-1:0]   mul_a;
   logic [DW-1:0]   mul_b;
   logic [RW-1:0]   mul_p;

   logic [RW:0]     sum;
   logic            ovf;
   logic [RW-1:0]   sum_sat;

   assign in_ready = (state == IDLE);

   // Multiplier operand steering: MUL1 forms p0, MUL2 forms the altitude p1.
   // The battery path needs no multiply in MUL2, so the mux just idles there.
   always_comb begin
      mul_a = ops.x1;
      mul_b = ops.x1;
      if (state == MUL2) begin
         mul_a = ops.x2;
         mul_b = ops.v;
      end else if (ops.sel) begin
         mul_a = ops.t;
         mul_b = ops.v;
      end
   end

   eq_mul #(.DW(DW)) u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   // One-bit-wider sum; the top two bits disagree exactly on overflow, and the
   // top bit then gives the direction to clamp toward.
   always_comb begin
      sum     = {p0[RW-1], p0} + {p1[RW-1], p1};
      ovf     = sum[RW] ^ sum[RW-1];
      sum_sat = sum[RW-1:0];
      if (ovf) sum_sat = sum[RW] ? SAT_MIN : SAT_MAX;
   end

   // Sequencer with registered datapath and outputs; out_valid is a one-cycle
   // pulse, out_sel and sat hold until the next write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ops       <= '0;
         p0        <= '0;
         p1        <= '0;
         result_a  <= '0;
         result_b  <= '0;
         out_valid <= 1'b0;
         out_sel   <= 1'b0;
         sat       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ops   <= '{sel: sel_eq, x1: x1, x2: x2, v: v, t: t, c: c};
                  state <= MUL1;
               end
            end
            MUL1: begin
               p0    <= mul_p;
               state <= MUL2;
            end
            MUL2: begin
               p1    <= ops.sel ? {{(RW-DW){ops.c[DW-1]}}, ops.c} : mul_p;
               state <= ADD;
            end
            ADD: begin
               if (ops.sel) result_b <= sum_sat;
               else         result_a <= sum_sat;
               out_valid <= 1'b1;
               out_sel   <= ops.sel;
               sat       <= ovf;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eq_compute_unit.sv
// Self-checking bench for eq_compute_unit: directed cases, randomized
// transactions, back-to-back busy handling and reset during an operation,
// all compared against an arithmetic reference model.
module tb_eq_compute_unit;
   localparam int DW = 8;
   localparam int RW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          sel_eq;
   logic [DW-1:0] x1, x2, v, t, c;
   logic [RW-1:0] result_a, result_b;
   logic          out_valid, out_sel, sat;

   int n_chk = 0;
   int n_err = 0;
   int exp_a = 0;
   int exp_b = 0;
   int exp_sel = 0;
   int exp_sat = 0;

   eq_compute_unit #(.DW(DW), .RW(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel_eq    (sel_eq),
      .x1        (x1),
      .x2        (x2),
      .v         (v),
      .t         (t),
      .c         (c),
      .result_a  (result_a),
      .result_b  (result_b),
      .out_valid (out_valid),
      .out_sel   (out_sel),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rnd8();
      logic signed [7:0] b;
      b = 8'($urandom);
      return int'(b);
   endfunction

   // Reference: plain integer arithmetic clamped to the signed 16-bit range.
   function automatic int model(input bit s_eq, input int a1, input int a2,
                                input int av, input int at, input int ac,
                                output bit s);
      int r;
      r = s_eq ? (at * av + ac) : (a1 * a1 + a2 * av);
      s = 1'b0;
      if (r > 32767) begin
         r = 32767;
         s = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         s = 1'b1;
      end
      return r;
   endfunction

   function automatic void expect_txn(input bit s_eq, input int a1, input int a2,
                                      input int av, input int at, input int ac);
      bit s;
      int r;
      r = model(s_eq, a1, a2, av, at, ac, s);
      if (s_eq) exp_b = r;
      else      exp_a = r;
      exp_sel = int'(s_eq);
      exp_sat = int'(s);
   endfunction

   task automatic drive_ops(input bit s_eq, input int a1, input int a2,
                            input int av, input int at, input int ac);
      sel_eq = s_eq;
      x1 = 8'(a1);
      x2 = 8'(a2);
      v  = 8'(av);
      t  = 8'(at);
      c  = 8'(ac);
   endtask

   task automatic check_results(input string tag);
      chk({tag, "_a"}, int'($signed(result_a)), exp_a);
      chk({tag, "_b"}, int'($signed(result_b)), exp_b);
   endtask

   // One transaction from an idle negedge: present for one edge, scramble the
   // inputs afterwards, then expect the pulse exactly three edges later.
   task automatic do_txn(input bit s_eq, input int a1, input int a2,
                         input int av, input int at, input int ac);
      int lat;
      chk("idle_rdy", int'(in_ready), 1);
      drive_ops(s_eq, a1, a2, av, at, ac);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      drive_ops(1'($urandom), rnd8(), rnd8(), rnd8(), rnd8(), rnd8());
      expect_txn(s_eq, a1, a2, av, at, ac);
      lat = 0;
      while (!out_valid && lat < 8) begin
         chk("busy_rdy", int'(in_ready), 0);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, 3);
      check_results("res");
      chk("out_sel", int'(out_sel), exp_sel);
      chk("sat", int'(sat), exp_sat);
      chk("done_rdy", int'(in_ready), 1);
      @(negedge clk);
      chk("pulse_end", int'(out_valid), 0);
      chk("sel_hold", int'(out_sel), exp_sel);
      chk("sat_hold", int'(sat), exp_sat);
      check_results("hold");
   endtask

   int bsel[8], bx1[8], bx2[8], bv[8], bt[8], bc[8];

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      drive_ops(1'b0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check_results("rst");
      chk("rst_rdy", int'(in_ready), 1);
      chk("rst_vld", int'(out_valid), 0);
      chk("rst_sel", int'(out_sel), 0);
      chk("rst_sat", int'(sat), 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      do_txn(1'b0, 3, 4, 5, 0, 0);              // 29
      do_txn(1'b1, 0, 0, 5, 2, 16);             // 26
      do_txn(1'b0, -128, -128, -128, 0, 0);     // 32768 -> 32767, sat
      do_txn(1'b0, 0, -128, 127, 0, 0);         // -16256
      do_txn(1'b1, 0, 0, 7, -3, -100);          // -121
      do_txn(1'b1, 0, 0, -128, -128, 127);      // 16511
      do_txn(1'b1, 0, 0, -128, 127, -128);      // -16384
      do_txn(1'b0, 127, 127, 127, 0, 0);        // 32258

      // Randomized transactions
      for (int i = 0; i < 40; i++)
         do_txn(1'($urandom), rnd8(), rnd8(), rnd8(), rnd8(), rnd8());

      // Busy: in_valid held for 8 cycles with fresh operands every cycle;
      // only cycles 0 and 4 should be taken.
      for (int k = 0; k < 12; k++) begin
         if (k < 8) begin
            bsel[k] = int'(1'($urandom));
            bx1[k] = rnd8(); bx2[k] = rnd8(); bv[k] = rnd8();
            bt[k]  = rnd8(); bc[k]  = rnd8();
            drive_ops(1'(bsel[k]), bx1[k], bx2[k], bv[k], bt[k], bc[k]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (k == 3 || k == 7) begin
            expect_txn(1'(bsel[k-3]), bx1[k-3], bx2[k-3], bv[k-3], bt[k-3], bc[k-3]);
            chk("busy_vld", int'(out_valid), 1);
            check_results("busy_res");
            chk("busy_sel", int'(out_sel), exp_sel);
            chk("busy_sat", int'(sat), exp_sat);
         end else begin
            chk("busy_novld", int'(out_valid), 0);
         end
      end

      // Reset while the operation sits in MUL2
      drive_ops(1'b0, 100, 90, 80, 0, 0);
      in_valid = 1'b1;
      @(negedge clk);                // accepted, now MUL1
      in_valid = 1'b0;
      @(negedge clk);                // now MUL2
      rst = 1'b1;
      #1;
      exp_a = 0;
      exp_b = 0;
      check_results("midrst");
      chk("midrst_rdy", int'(in_ready), 1);
      chk("midrst_vld", int'(out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("midrst_novld", int'(out_valid), 0);
      end
      check_results("midrst_after");

      do_txn(1'b0, 3, 4, 5, 0, 0);
      do_txn(1'b1, 0, 0, 7, -3, -100);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
